// File: rtl/video_fb.sv
// -----------------------------------------------------------------------------
// video_fb : VGA scan-out engine
//
// Generates VGA timing, draws a solid border around a framebuffer window,
// fetches packed pixels from a 1-cycle-latency video RAM and expands each
// pixel index through a 16-entry RGB888 palette.
//
// Pipeline (all outputs are exactly three clocks behind the raster counters):
//   stage0 : hc/vc counters, timing decode, video RAM address generation
//   stage1 : registered timing flags (RAM read in flight)
//   stage2 : pixel shift register loaded from vid_dout
//   stage3 : palette lookup / border / blanking mux, sync and enable outputs
//
// Ports
//   clk        : pixel clock
//   reset      : synchronous reset, active low
//   vid_addr   : video RAM word address (registered)
//   vid_dout   : video RAM data, valid one clock after vid_addr
//   fb_base    : framebuffer base word address, latched at each vblank
//   border_col : border colour {r,g,b}
//   pal_we     : palette write strobe
//   pal_addr   : palette write index
//   pal_data   : palette write data {r,g,b}
//   vga_r/g/b  : colour outputs
//   vga_hs/vs  : horizontal / vertical sync (polarity set by HS_POL / VS_POL)
//   vga_de     : data enable (active area)
//   vblank     : one-clock pulse at the start of vertical blanking
//
// SCALE*(DW/BPP) (clocks per fetched word) must be a power of two.
// -----------------------------------------------------------------------------
module video_fb #(
    parameter int HA     = 640,
    parameter int HFP    = 16,
    parameter int HS     = 96,
    parameter int HBP    = 48,
    parameter int VA     = 480,
    parameter int VFP    = 11,
    parameter int VS     = 2,
    parameter int VBP    = 31,
    parameter int HB     = 64,
    parameter int VB     = 112,
    parameter int SCALE  = 2,
    parameter int BPP    = 4,
    parameter int DW     = 8,
    parameter int AW     = 15,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    output logic [AW-1:0] vid_addr,
    input  logic [DW-1:0] vid_dout,
    input  logic [AW-1:0] fb_base,
    input  logic [23:0]   border_col,
    input  logic          pal_we,
    input  logic [3:0]    pal_addr,
    input  logic [23:0]   pal_data,
    output logic [7:0]    vga_r,
    output logic [7:0]    vga_g,
    output logic [7:0]    vga_b,
    output logic          vga_hs,
    output logic          vga_vs,
    output logic          vga_de,
    output logic          vblank
);

    localparam int HT     = HA + HFP + HS + HBP;
    localparam int VT     = VA + VFP + VS + VBP;
    localparam int PPW    = DW / BPP;
    localparam int WCLK   = SCALE * PPW;            // clocks spent on one RAM word
    localparam int STRIDE = (HA - 2 * HB) / WCLK;   // words per framebuffer line
    localparam int HCW    = $clog2(HT);
    localparam int VCW    = $clog2(VT);

    localparam logic [HCW-1:0] H_LAST = HCW'(HT - 1);
    localparam logic [HCW-1:0] H_ACT  = HCW'(HA);
    localparam logic [HCW-1:0] H_SS   = HCW'(HA + HFP);
    localparam logic [HCW-1:0] H_SE   = HCW'(HA + HFP + HS);
    localparam logic [HCW-1:0] H_WS   = HCW'(HB);
    localparam logic [HCW-1:0] H_WE   = HCW'(HA - HB);
    localparam logic [HCW-1:0] S_MASK = HCW'(SCALE - 1);
    localparam logic [HCW-1:0] W_MASK = HCW'(WCLK - 1);

    localparam logic [VCW-1:0] V_LAST = VCW'(VT - 1);
    localparam logic [VCW-1:0] V_ACT  = VCW'(VA);
    localparam logic [VCW-1:0] V_SS   = VCW'(VA + VFP);
    localparam logic [VCW-1:0] V_SE   = VCW'(VA + VFP + VS);
    localparam logic [VCW-1:0] V_WS   = VCW'(VB);
    localparam logic [VCW-1:0] V_WE   = VCW'(VA - VB);

    localparam logic [AW-1:0]  STRIDE_A = AW'(STRIDE);

    // Timing flags carried from stage0 to stage1; sync flags are active-true
    // here and converted to the requested polarity only at the output.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic border;
        logic vbl;
        logic wstart;   // first clock of a fetched word: load the shifter
        logic pstart;   // first clock of a pixel: advance the shifter
    } ctl_t;

    // Reset palette: CGA-like 16 colours. Component bit r=idx[1], g=idx[2],
    // b=idx[0]; idx[3] brightens both the on and off levels.
    function automatic logic [23:0] pal_default(input logic [3:0] idx);
        logic [7:0] on_lvl;
        logic [7:0] off_lvl;
        on_lvl  = idx[3] ? 8'hFF : 8'hAA;
        off_lvl = idx[3] ? 8'h55 : 8'h00;
        return {idx[1] ? on_lvl : off_lvl,
                idx[2] ? on_lvl : off_lvl,
                idx[0] ? on_lvl : off_lvl};
    endfunction

    // ------------------------------------------------------------------ stage0
    logic [HCW-1:0] hc;
    logic [VCW-1:0] vc;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!reset) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
        end else begin
            hc <= hc + 1'b1;
        end
    end

    ctl_t           s0;
    logic           s0_row;
    logic           s0_win;
    logic           fetch_go;
    logic           fetch_first;
    logic [HCW-1:0] rel;
    logic [HCW-1:0] hc_next;
    logic [HCW-1:0] rel_next;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // can leave it unassigned and infer a latch.
        s0          = '0;
        s0_row      = 1'b0;
        s0_win      = 1'b0;
        fetch_go    = 1'b0;
        fetch_first = 1'b0;
        rel         = hc - H_WS;
        hc_next     = hc + 1'b1;
        rel_next    = hc_next - H_WS;

        s0_row    = (vc >= V_WS) && (vc < V_WE);
        s0.de     = (hc < H_ACT) && (vc < V_ACT);
        s0.hs     = (hc >= H_SS) && (hc < H_SE);
        s0.vs     = (vc >= V_SS) && (vc < V_SE);
        s0.border = (hc < H_WS) || (hc >= H_WE) || !s0_row;
        s0.vbl    = (vc == V_ACT) && (hc == '0);
        s0_win    = s0.de && !s0.border;
        s0.wstart = s0_win && ((rel & W_MASK) == '0);
        s0.pstart = s0_win && ((rel & S_MASK) == '0);

        // The address for a word must be on vid_addr while its first pixel
        // is at stage0, so it is registered one clock earlier: look at hc+1.
        fetch_go    = s0_row && (hc_next >= H_WS) && (hc_next < H_WE)
                      && ((rel_next & W_MASK) == '0);
        fetch_first = (hc_next == H_WS);
    end

    // Framebuffer addressing: fb_lat only changes at vblank so a base change
    // never tears the frame being scanned. line_addr steps by STRIDE after
    // every SCALE-th window line (addition only, no multiplier).
    logic [AW-1:0] fb_lat;
    logic [AW-1:0] line_addr;
    logic          line_rep;

    always_ff @(posedge clk) begin
        if (!reset) begin
            fb_lat    <= fb_base;
            line_addr <= '0;
            line_rep  <= 1'b0;
            vid_addr  <= '0;
        end else begin
            if (s0.vbl) begin
                fb_lat <= fb_base;
            end

            if (hc == '0 && vc == V_WS) begin
                line_addr <= fb_lat;
                line_rep  <= 1'b0;
            end else if (hc == H_LAST && s0_row) begin
                if (SCALE == 1 || line_rep) begin
                    line_addr <= line_addr + STRIDE_A;
                    line_rep  <= 1'b0;
                end else begin
                    line_rep <= 1'b1;
                end
            end

            // Outside the window vid_addr simply holds; wraps modulo 2^AW.
            if (fetch_go) begin
                vid_addr <= fetch_first ? line_addr : vid_addr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------ stage1
    ctl_t s1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1 <= '0;
        end else begin
            s1 <= s0;
        end
    end

    // ------------------------------------------------------------------ stage2
    // vid_dout during stage1 belongs to the word addressed during stage0, so
    // the shifter holds the current pixel in its MSBs at stage2.
    logic          s2_de;
    logic          s2_hs;
    logic          s2_vs;
    logic          s2_border;
    logic          s2_vbl;
    logic [DW-1:0] shifter;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s2_de     <= 1'b0;
            s2_hs     <= 1'b0;
            s2_vs     <= 1'b0;
            s2_border <= 1'b0;
            s2_vbl    <= 1'b0;
            shifter   <= '0;
        end else begin
            s2_de     <= s1.de;
            s2_hs     <= s1.hs;
            s2_vs     <= s1.vs;
            s2_border <= s1.border;
            s2_vbl    <= s1.vbl;
            if (s1.wstart) begin
                shifter <= vid_dout;
            end else if (s1.pstart) begin
                shifter <= shifter << BPP;
            end
        end
    end

    // ------------------------------------------------------------------ palette
    logic [23:0] pal [16];

    always_ff @(posedge clk) begin
        // NOTE: the palette is a small register array, so it is reset to its
        // default colours on every reset pulse, not just at power-up.
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                pal[i] <= pal_default(4'(i));
            end
        end else if (pal_we) begin
            pal[pal_addr] <= pal_data;
        end
    end

    // ------------------------------------------------------------------ stage3
    // A write in the same clock as a read returns the old entry, since the
    // read below sees the array before the write lands.
    logic [3:0]  pix;
    logic [23:0] rgb;

    assign pix = 4'(shifter[DW-1 -: BPP]);

    always_ff @(posedge clk) begin
        if (!reset) begin
            rgb    <= '0;
            vga_de <= 1'b0;
            vga_hs <= !HS_POL;
            vga_vs <= !VS_POL;
            vblank <= 1'b0;
        end else begin
            vga_de <= s2_de;
            vga_hs <= s2_hs ? HS_POL : !HS_POL;
            vga_vs <= s2_vs ? VS_POL : !VS_POL;
            vblank <= s2_vbl;
            if (!s2_de) begin
                rgb <= '0;
            end else if (s2_border) begin
                rgb <= border_col;
            end else begin
                rgb <= pal[pix];
            end
        end
    end

    assign {vga_r, vga_g, vga_b} = rgb;

endmodule

// File: tb/tb_video_fb.sv
// -----------------------------------------------------------------------------
// tb_video_fb : directed bench for video_fb
//
// Two instances share clock, reset and control inputs:
//   u_dut   : default 800x524 timing, used for reset, de, hc wrap and hsync.
//   u_small : reduced 48x32 timing so whole frames are short; used for fetch,
//             palette, border, vsync, vblank and framebuffer base behaviour.
// Small geometry: HT=48, VT=32, window hc 8..23, vc 6..17, 4 words/line.
//
// Time reference: `edges` counts posedges since the last reset release and
// all sampling happens on the falling edge. At edges==q the stage0 raster
// position is q; outputs for raster position p are visible at edges==p+3.
// -----------------------------------------------------------------------------
module tb_video_fb;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [14:0] fb_base;
    logic [23:0] border_col;
    logic        pal_we;
    logic [3:0]  pal_addr;
    logic [23:0] pal_data;

    logic [14:0] d_vaddr, s_vaddr;
    logic [7:0]  d_dout, s_dout;
    logic [7:0]  d_r, d_g, d_b, s_r, s_g, s_b;
    logic        d_hs, d_vs, d_de, d_vbl;
    logic        s_hs, s_vs, s_de, s_vbl;

    logic [7:0]  mem [32768];

    int n_tests = 0;
    int n_fail  = 0;
    int edges   = 0;

    always #5 clk = ~clk;

    // 1-cycle-latency video RAM model, one read port per instance
    always @(posedge clk) begin
        d_dout <= mem[d_vaddr];
        s_dout <= mem[s_vaddr];
    end

    video_fb u_dut (
        .clk(clk), .reset(reset), .vid_addr(d_vaddr), .vid_dout(d_dout),
        .fb_base(fb_base), .border_col(border_col), .pal_we(pal_we),
        .pal_addr(pal_addr), .pal_data(pal_data),
        .vga_r(d_r), .vga_g(d_g), .vga_b(d_b),
        .vga_hs(d_hs), .vga_vs(d_vs), .vga_de(d_de), .vblank(d_vbl)
    );

    video_fb #(
        .HA(32), .HFP(4), .HS(6), .HBP(6),
        .VA(24), .VFP(2), .VS(2), .VBP(4),
        .HB(8), .VB(6)
    ) u_small (
        .clk(clk), .reset(reset), .vid_addr(s_vaddr), .vid_dout(s_dout),
        .fb_base(fb_base), .border_col(border_col), .pal_we(pal_we),
        .pal_addr(pal_addr), .pal_data(pal_data),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
        .vga_hs(s_hs), .vga_vs(s_vs), .vga_de(s_de), .vblank(s_vbl)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the falling edge where `edges` equals e (always bounded).
    task automatic goto_edge(input int e);
        while (edges < e) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic at_out(input int p);
        goto_edge(p + 3);
    endtask

    task automatic check_reset_state(input string sfx);
        check({"d_rgb_rst", sfx}, 32'({d_r, d_g, d_b}), 32'h0);
        check({"d_de_rst", sfx},  32'(d_de),  32'd0);
        check({"d_vbl_rst", sfx}, 32'(d_vbl), 32'd0);
        check({"d_hs_rst", sfx},  32'(d_hs),  32'd1);
        check({"d_vs_rst", sfx},  32'(d_vs),  32'd1);
        check({"d_vaddr_rst", sfx}, 32'(d_vaddr), 32'h0);
        check({"s_rgb_rst", sfx}, 32'({s_r, s_g, s_b}), 32'h0);
        check({"s_de_rst", sfx},  32'(s_de),  32'd0);
        check({"s_vaddr_rst", sfx}, 32'(s_vaddr), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
        mem[15'h0000] = 8'h12;
        mem[15'h0001] = 8'h34;
        mem[15'h0004] = 8'h56;
        mem[15'h4000] = 8'h7F;
        mem[15'h4001] = 8'h10;

        fb_base    = 15'h0000;
        border_col = 24'h123456;
        pal_we     = 1'b0;
        pal_addr   = 4'h0;
        pal_data   = 24'h0;

        // Reset held for five clocks, then released on a falling edge.
        repeat (5) @(negedge clk);
        reset = 1'b1;
        edges = 0;
        check_reset_state("");

        // ---- default timing: latency, de window, hsync, hc wrap
        at_out(-1);  check("d_de_before", 32'(d_de), 32'd0);
        at_out(0);   check("d_de_first", 32'(d_de), 32'd1);
                     check("d_border_origin", 32'({d_r, d_g, d_b}), 32'h123456);
        at_out(639); check("d_de_last", 32'(d_de), 32'd1);
        at_out(640); check("d_de_off", 32'(d_de), 32'd0);
                     check("d_rgb_blank", 32'({d_r, d_g, d_b}), 32'h0);
        at_out(655); check("d_hs_pre", 32'(d_hs), 32'd1);
        at_out(656); check("d_hs_start", 32'(d_hs), 32'd0);
        at_out(751); check("d_hs_end", 32'(d_hs), 32'd0);
        at_out(752); check("d_hs_post", 32'(d_hs), 32'd1);
        at_out(799); check("d_de_hc799", 32'(d_de), 32'd0);
        at_out(800); check("d_de_wrap", 32'(d_de), 32'd1);

        // ---- small timing, frame 1 (starts at 1536), window row 6 origin 1832
        goto_edge(1831); check("s_vaddr_hold_prev", 32'(s_vaddr), 32'd23);
        goto_edge(1832); check("s_vaddr_w0", 32'(s_vaddr), 32'd0);
        at_out(1831);    check("s_border_left", 32'({s_r, s_g, s_b}), 32'h123456);
        goto_edge(1835); check("s_vaddr_w0_hold", 32'(s_vaddr), 32'd0);
                         check("s_px0a", 32'({s_r, s_g, s_b}), 32'h0000AA);
        goto_edge(1836); check("s_vaddr_w1", 32'(s_vaddr), 32'd1);
                         check("s_px0b", 32'({s_r, s_g, s_b}), 32'h0000AA);
        at_out(1834);    check("s_px1", 32'({s_r, s_g, s_b}), 32'hAA0000);
        goto_edge(1840); check("s_vaddr_w2", 32'(s_vaddr), 32'd2);
        at_out(1838);    check("s_px3", 32'({s_r, s_g, s_b}), 32'h00AA00);
        at_out(1848);    check("s_border_right", 32'({s_r, s_g, s_b}), 32'h123456);

        // Palette write during row 6 blanking; row 7 repeats row 6's words.
        goto_edge(1854);
        pal_we = 1'b1; pal_addr = 4'd1; pal_data = 24'hFF0000;
        goto_edge(1855);
        pal_we = 1'b0;
        goto_edge(1880); check("s_vaddr_row7", 32'(s_vaddr), 32'd0);
        at_out(1880);    check("s_pal_write", 32'({s_r, s_g, s_b}), 32'hFF0000);

        // Base change mid-frame: row 8 still uses the old base.
        goto_edge(1902);
        fb_base = 15'h4000;
        goto_edge(1928); check("s_vaddr_row8", 32'(s_vaddr), 32'd4);
        at_out(1928);    check("s_px_row8a", 32'({s_r, s_g, s_b}), 32'h00AAAA);
        at_out(1930);    check("s_px_row8b", 32'({s_r, s_g, s_b}), 32'hAAAA00);

        // vblank pulse at (24,0) = 2688, vsync on rows 26..27
        at_out(2687); check("s_vbl_pre", 32'(s_vbl), 32'd0);
        at_out(2688); check("s_vbl_pulse", 32'(s_vbl), 32'd1);
        at_out(2689); check("s_vbl_post", 32'(s_vbl), 32'd0);
        at_out(2783); check("s_vs_pre", 32'(s_vs), 32'd1);
        at_out(2784); check("s_vs_start", 32'(s_vs), 32'd0);
        at_out(2879); check("s_vs_end", 32'(s_vs), 32'd0);
        at_out(2880); check("s_vs_post", 32'(s_vs), 32'd1);

        // ---- frame 2 (starts at 3072): new base in effect
        at_out(3322);    check("s_border_top", 32'({s_r, s_g, s_b}), 32'h123456);
        goto_edge(3368); check("s_vaddr_newbase", 32'(s_vaddr), 32'h4000);
        at_out(3368);    check("s_px_newbase_a", 32'({s_r, s_g, s_b}), 32'hAAAAAA);
        at_out(3370);    check("s_px_newbase_b", 32'({s_r, s_g, s_b}), 32'hFFFFFF);
        at_out(3400);    check("s_rgb_hblank", 32'({s_r, s_g, s_b}), 32'h0);
                         check("s_de_hblank", 32'(s_de), 32'd0);

        // ---- one-clock reset mid-line (default instance at hc=300)
        goto_edge(3500); check("s_vaddr_before_rst", 32'(s_vaddr), 32'h4007);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        edges = 0;
        check_reset_state("_mid");
        at_out(0);      check("d_de_restart", 32'(d_de), 32'd1);
        goto_edge(296); check("s_vaddr_rst_base", 32'(s_vaddr), 32'h4000);
        at_out(300);    check("s_pal_after_rst", 32'({s_r, s_g, s_b}), 32'h0000AA);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
